// File: rtl/coherence_controller.sv
// Shared-memory coherence responder: round-robin grants one core's miss or store,
// snoops peers, writes back dirty peer data, and drives the SSRAM and L1 fill path.
module coherence_controller #(
  parameter int N_CORES  = 4,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int SRAM_LAT = 2
) (
  input  logic                        new_clock,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          mem_req,
  input  logic [N_CORES-1:0]          mem_we,
  input  logic [N_CORES-1:0]          mem_hit,
  input  logic [N_CORES*ADDR_W-1:0]   mem_addr,
  input  logic [N_CORES*DATA_W-1:0]   mem_wd,
  input  logic [N_CORES-1:0]          snoop_dirty,
  input  logic [N_CORES*DATA_W-1:0]   snoop_data,
  output logic [N_CORES-1:0]          stall_me,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic [N_CORES-1:0]          invalidate,
  output logic [N_CORES-1:0]          fill_valid,
  output logic [DATA_W-1:0]           fill_data,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wd,
  input  logic [DATA_W-1:0]           sram_rd,
  output logic                        sram_gw,
  output logic                        sram_oe
);
  localparam int CW = $clog2(N_CORES);
  localparam int LW = $clog2(SRAM_LAT + 1);

  typedef enum logic [2:0] {IDLE, SNOOP, WB, READ, WRITE, FILL, DONE} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  grant_q, rr_ptr_q, pick, peer_d;
  logic [CW:0]                    cand;
  logic                           found, any_dirty;
  logic [N_CORES-1:0]             need, grant_oh, dirty_m;
  logic [N_CORES-1:0][ADDR_W-1:0] addr_v;
  logic [N_CORES-1:0][DATA_W-1:0] wd_v, sdata_v;
  logic [ADDR_W-1:0]              addr_q;
  logic                           we_q;
  logic [DATA_W-1:0]              wd_q;
  logic [LW-1:0]                  rd_cnt_q;

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    assign need[i]     = mem_req[i] & (~mem_hit[i] | mem_we[i]);
    assign stall_me[i] = need[i] & ~(state_q == DONE && grant_q == CW'(i));
    assign addr_v[i]   = mem_addr[i*ADDR_W +: ADDR_W];
    assign wd_v[i]     = mem_wd[i*DATA_W +: DATA_W];
    assign sdata_v[i]  = snoop_data[i*DATA_W +: DATA_W];
  end

  assign grant_oh = {{(N_CORES-1){1'b0}}, 1'b1} << grant_q;

  // Round-robin: first needing core at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = '0;
    for (int k = 0; k < N_CORES; k++) begin
      cand = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (cand >= (CW+1)'(N_CORES)) cand = cand - (CW+1)'(N_CORES);
      if (!found && need[cand]) begin
        found = 1'b1;
        pick  = cand[CW-1:0];
      end
    end
  end

  // The requester's own dirty bit is meaningless; lowest-index dirty peer wins.
  always_comb begin
    dirty_m   = snoop_dirty & ~grant_oh;
    any_dirty = |dirty_m;
    peer_d    = '0;
    for (int k = N_CORES-1; k >= 0; k--)
      if (dirty_m[k]) peer_d = CW'(k);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = SNOOP;
      SNOOP:   state_d = any_dirty ? WB : (we_q ? WRITE : READ);
      WB:      state_d = we_q ? WRITE : FILL;
      READ:    if (rd_cnt_q == LW'(SRAM_LAT-1)) state_d = FILL;
      WRITE:   state_d = FILL;
      FILL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with it.
  always_ff @(posedge new_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wd_q       <= '0;
      rd_cnt_q   <= '0;
      snoop_addr <= '0;
      sram_addr  <= '0;
      sram_wd    <= '0;
      fill_data  <= '0;
      sram_gw    <= 1'b1;
      sram_oe    <= 1'b1;
      invalidate <= '0;
      fill_valid <= '0;
    end else begin
      state_q    <= state_d;
      sram_gw    <= ~(state_d == WB || state_d == WRITE);
      sram_oe    <= ~(state_d == READ);
      invalidate <= (state_d == WRITE) ? ~grant_oh : '0;
      fill_valid <= (state_d == FILL) ? grant_oh : '0;
      rd_cnt_q   <= (state_q == READ) ? rd_cnt_q + 1'b1 : '0;
      if (state_q == IDLE && found) begin
        grant_q    <= pick;
        rr_ptr_q   <= (pick == CW'(N_CORES-1)) ? '0 : pick + 1'b1;
        addr_q     <= addr_v[pick];
        we_q       <= mem_we[pick];
        wd_q       <= wd_v[pick];
        snoop_addr <= addr_v[pick];
      end
      if (state_d == WB || state_d == READ || state_d == WRITE || state_d == FILL)
        sram_addr <= addr_q;
      if (state_d == WB) begin
        sram_wd   <= sdata_v[peer_d];
        fill_data <= sdata_v[peer_d];
      end
      if (state_d == WRITE) begin
        sram_wd   <= wd_q;
        fill_data <= wd_q;
      end
      if (state_q == READ && state_d == FILL)
        fill_data <= sram_rd;
    end
  end
endmodule

// File: tb/tb_coherence_controller.sv
// Bench for coherence_controller: transaction-level expectation queue checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_coherence_controller;
  localparam int N = 4, AW = 6, DW = 32, LAT = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0]    mem_req = '0, mem_we = '0, mem_hit = '0, snoop_dirty = '0;
  logic [N*AW-1:0] mem_addr = '0;
  logic [N*DW-1:0] mem_wd = '0, snoop_data = '0;
  logic [N-1:0]    stall_me, invalidate, fill_valid;
  logic [AW-1:0]   snoop_addr, sram_addr;
  logic [DW-1:0]   fill_data, sram_wd, sram_rd;
  logic            sram_gw, sram_oe;

  coherence_controller #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT)) dut (
    .new_clock(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_hit(mem_hit),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
    .stall_me(stall_me), .snoop_addr(snoop_addr), .invalidate(invalidate),
    .fill_valid(fill_valid), .fill_data(fill_data), .sram_addr(sram_addr), .sram_wd(sram_wd),
    .sram_rd(sram_rd), .sram_gw(sram_gw), .sram_oe(sram_oe));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, errs = 0;
  bit chk_en = 1'b0;
  logic [N-1:0] last_ret = '0;

  // SSRAM behavioural model
  logic [DW-1:0] mem [64];
  assign sram_rd = mem[sram_addr];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (!sram_gw) mem[sram_addr] <= sram_wd;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected per-cycle record for one transaction, generated when the grant happens
  typedef struct {
    bit            oe_lo, gw_lo, snp, done;
    logic [N-1:0]  fv, inv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, fd;
  } rec_t;

  rec_t          q[$];
  rec_t          cur;
  int            rr = 0;
  logic [N-1:0]  oh_m = '0, need_m;
  logic [DW-1:0] ref_mem [64];

  task automatic start_txn(input logic [N-1:0] nd);
    int g;
    logic [N-1:0] dm;
    logic [DW-1:0] pd, w, fill;
    logic [AW-1:0] a;
    logic we;
    bit dirty;
    rec_t r;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && nd[(rr+k)%N]) g = (rr + k) % N;
    rr = (g + 1) % N;
    oh_m = '0; oh_m[g] = 1'b1;
    a  = mem_addr[g*AW +: AW];
    we = mem_we[g];
    w  = mem_wd[g*DW +: DW];
    dm = snoop_dirty & ~oh_m;
    dirty = (dm != 0);
    pd = '0;
    for (int k = N-1; k >= 0; k--) if (dm[k]) pd = snoop_data[k*DW +: DW];
    r = '{default:0}; r.snp = 1; r.addr = a; q.push_back(r);
    fill = '0;
    if (dirty) begin
      r = '{default:0}; r.gw_lo = 1; r.addr = a; r.wd = pd; q.push_back(r);
      ref_mem[a] = pd;
    end
    if (we) begin
      r = '{default:0}; r.gw_lo = 1; r.addr = a; r.wd = w; r.inv = ~oh_m; q.push_back(r);
      ref_mem[a] = w;
      fill = w;
    end else if (dirty) begin
      fill = pd;
    end else begin
      fill = ref_mem[a];
      for (int k = 0; k < LAT; k++) begin
        r = '{default:0}; r.oe_lo = 1; r.addr = a; q.push_back(r);
      end
    end
    r = '{default:0}; r.fv = oh_m; r.addr = a; r.fd = fill; q.push_back(r);
    r = '{default:0}; r.done = 1; q.push_back(r);
  endtask

  // Model + per-cycle compare
  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + i;
    ref_mem[5] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        need_m = mem_req & (~mem_hit | mem_we);
        cur = '{default:0};
        if (q.size() > 0) cur = q.pop_front();
        else if (!reset && need_m != 0) start_txn(need_m);
        chk("stall_me", stall_me, need_m & ~(cur.done ? oh_m : '0));
        chk("sram_gw", sram_gw, !cur.gw_lo);
        chk("sram_oe", sram_oe, !cur.oe_lo);
        chk("fill_valid", fill_valid, cur.fv);
        chk("invalidate", invalidate, cur.inv);
        if (cur.gw_lo) begin
          chk("wr_addr", sram_addr, cur.addr);
          chk("wr_data", sram_wd, cur.wd);
        end
        if (cur.oe_lo) chk("rd_addr", sram_addr, cur.addr);
        if (cur.fv != 0) begin
          chk("fill_data", fill_data, cur.fd);
          chk("fill_addr", sram_addr, cur.addr);
        end
        if (cur.snp) chk("snoop_addr", snoop_addr, cur.addr);
        if (reset) begin
          q.delete();
          rr = 0;
        end
      end
    end
  end

  // One cycle; cores whose stall dropped this cycle retire their request.
  task automatic step();
    logic [N-1:0] r;
    @(negedge clk);
    r = mem_req & (~mem_hit | mem_we) & ~stall_me;
    @(posedge clk); #1;
    mem_req  = mem_req & ~r;
    last_ret = r;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) step();
  endtask

  task automatic req(input int i, input logic we, input logic hit,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_req[i] = 1'b1; mem_we[i] = we; mem_hit[i] = hit;
    mem_addr[i*AW +: AW] = a;
    mem_wd[i*DW +: DW] = d;
  endtask

  task automatic wait_all(input int budget, input string nm);
    int k = 0;
    while ((mem_req & (~mem_hit | mem_we)) != 0 && k < budget) begin
      step();
      k++;
    end
    chk({"timeout_", nm}, mem_req & (~mem_hit | mem_we), '0);
  endtask

  initial begin
    int c0, first, k;
    int ord[$];
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    // reset state
    chk("rst_gw", sram_gw, 1); chk("rst_oe", sram_oe, 1);
    chk("rst_fv", fill_valid, 0); chk("rst_inv", invalidate, 0);
    chk("rst_addr", sram_addr, 0); chk("rst_fd", fill_data, 0);
    chk("rst_stall", stall_me, 0);

    // core1 clean load miss
    req(1, 0, 0, 6'h05, 0); c0 = cyc;
    at_cycle(c0+2); chk("t1_oe_c2", sram_oe, 0); chk("t1_addr_c2", sram_addr, 6'h05);
    at_cycle(c0+3); chk("t1_oe_c3", sram_oe, 0);
    at_cycle(c0+4); chk("t1_fv", fill_valid, 4'b0010); chk("t1_fd", fill_data, 32'hDEAD_BEEF);
    chk("t1_stall_c4", stall_me[1], 1);
    at_cycle(c0+5); chk("t1_stall_c5", stall_me[1], 0);
    wait_all(40, "t1");

    // core0 store hit
    req(0, 1, 1, 6'h10, 32'h1234); c0 = cyc;
    at_cycle(c0+2); chk("t2_gw", sram_gw, 0); chk("t2_wd", sram_wd, 32'h1234);
    chk("t2_inv", invalidate, 4'b1110);
    at_cycle(c0+3); chk("t2_fv", fill_valid, 4'b0001); chk("t2_stall_c3", stall_me[0], 1);
    at_cycle(c0+4); chk("t2_stall_c4", stall_me[0], 0);
    wait_all(40, "t2");

    // core2 load miss, core3 dirty (core2's own dirty bit must be ignored)
    snoop_dirty = 4'b1100;
    snoop_data[2*DW +: DW] = 32'hBAD0_0002;
    snoop_data[3*DW +: DW] = 32'hCAFE_0001;
    req(2, 0, 0, 6'h3F, 0); c0 = cyc;
    at_cycle(c0+2); chk("t3_gw", sram_gw, 0); chk("t3_wd", sram_wd, 32'hCAFE_0001);
    chk("t3_oe_c2", sram_oe, 1);
    at_cycle(c0+3); chk("t3_fv", fill_valid, 4'b0100); chk("t3_fd", fill_data, 32'hCAFE_0001);
    chk("t3_oe_c3", sram_oe, 1);
    wait_all(40, "t3");

    // core1 store with core0 dirty: writeback then write
    snoop_dirty = 4'b0001;
    snoop_data[0 +: DW] = 32'h77;
    req(1, 1, 0, 6'h07, 32'h55); c0 = cyc;
    at_cycle(c0+2); chk("t4_wb_wd", sram_wd, 32'h77);
    at_cycle(c0+3); chk("t4_wr_wd", sram_wd, 32'h55); chk("t4_inv", invalidate, 4'b1101);
    at_cycle(c0+4); chk("t4_fv", fill_valid, 4'b0010); chk("t4_fd", fill_data, 32'h55);
    at_cycle(c0+5); chk("t4_stall_c5", stall_me[1], 0);
    wait_all(40, "t4");
    snoop_dirty = '0;

    // stored word comes back on a later clean miss
    req(3, 0, 0, 6'h10, 0); c0 = cyc;
    at_cycle(c0+4); chk("t5_fd", fill_data, 32'h1234);
    wait_all(40, "t5");

    // round-robin from pointer 0
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < N; i++) req(i, 0, 0, AW'(i+1), 0);
    k = 0;
    while (mem_req != 0 && k < 200) begin
      step(); k++;
      for (int j = 0; j < N; j++) if (last_ret[j]) ord.push_back(j);
    end
    chk("rr_count", ord.size(), 4);
    for (int j = 0; j < ord.size() && j < 4; j++) chk("rr_order", ord[j], j);
    req(0, 0, 0, 6'h08, 0); req(2, 0, 0, 6'h0C, 0);
    first = -1; k = 0;
    while (first < 0 && k < 100) begin
      step(); k++;
      for (int j = N-1; j >= 0; j--) if (last_ret[j]) first = j;
    end
    chk("rr_wrap", first, 0);
    wait_all(40, "rr");

    // reset during READ of core3; core1 wins afterwards from pointer 0
    req(1, 0, 0, 6'h05, 0); req(3, 0, 0, 6'h09, 0); c0 = cyc;
    at_cycle(c0+2); chk("t6_oe_read", sram_oe, 0); chk("t6_addr", sram_addr, 6'h09);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_oe_after", sram_oe, 1); chk("t6_fv_after", fill_valid, 0);
    first = -1; k = 0;
    while (first < 0 && k < 100) begin
      step(); k++;
      for (int j = N-1; j >= 0; j--) if (last_ret[j]) first = j;
    end
    chk("t6_regrant", first, 1);
    wait_all(40, "t6");

    // load hit is never serviced
    req(0, 0, 1, 6'h05, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hit_stall", stall_me, 0); chk("hit_gw", sram_gw, 1); chk("hit_oe", sram_oe, 1);
    end
    mem_req = '0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
